// File: rtl/sc_match_serializer_pkg.sv
// Shared defaults and helpers for the match serializer: default channel count,
// timestamp width, index-width rule and the per-channel slice of match_time.
package sc_match_serializer_pkg;

  localparam int N_CH_DEF = 37;
  localparam int TW_DEF   = 16;

  // A single-channel build still needs a 1-bit index so ports never collapse.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of channel k inside the flattened match_time bus.
  function automatic int ch_lsb(input int k, input int tw);
    return k * tw;
  endfunction

endpackage

// File: rtl/sc_match_serializer_rr_arbiter.sv
// Round-robin picker: lowest requesting index at or above ptr, else lowest
// requesting index below ptr. Purely combinational, gated by en.
module rr_arbiter
  import sc_match_serializer_pkg::*;
#(
  parameter int N  = N_CH_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic          hit;
  logic [IW-1:0] idx;

  // Two descending sweeps: the upper-region sweep runs last so it overrides
  // any wrapped (below-ptr) candidate, and the lowest index wins within each.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j < int'(ptr))) begin
        hit = 1'b1;
        idx = IW'(j);
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j >= int'(ptr))) begin
        hit = 1'b1;
        idx = IW'(j);
      end
    end
  end

  assign gnt_valid = en & hit;
  assign gnt_idx   = idx;

endmodule

// File: rtl/sc_match_serializer.sv
// Captures per-channel match triggers into pending slots and drains them
// round-robin as (channel, song_time - match_time) records on one stream.
module sc_match_serializer
  import sc_match_serializer_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int TW   = TW_DEF,
  parameter int IDW  = idx_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TW-1:0]    song_time,
  input  logic [N_CH-1:0]  match_trigger,
  input  logic [N_CH*TW-1:0] match_time,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDW-1:0]   out_ch,
  output logic [TW-1:0]    out_dt,
  output logic [N_CH-1:0]  pending,
  output logic             overflow,
  input  logic             ovf_clr
);

  // Stream handshake: a record transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low,
  // out_ch/out_dt hold steady and no new record is loaded.

  logic [TW-1:0]   time_q [N_CH];
  logic [N_CH-1:0] pending_q;
  logic [IDW-1:0]  ptr_q;
  logic            out_free;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_idx;
  logic [N_CH-1:0] gnt_hot;
  logic [N_CH-1:0] accept;
  logic            drop;

  assign out_free = ~out_valid | out_ready;

  rr_arbiter #(.N(N_CH), .IW(IDW)) u_arb (
    .req       (pending_q),
    .ptr       (ptr_q),
    .en        (out_free),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A trigger is accepted into a free slot, or into a slot being drained this
  // same cycle; otherwise it is dropped and flagged.
  always_comb begin
    gnt_hot = '0;
    accept  = '0;
    drop    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      gnt_hot[k] = gnt_valid && (gnt_idx == IDW'(k));
      accept[k]  = match_trigger[k] && (!pending_q[k] || gnt_hot[k]);
      if (match_trigger[k] && !accept[k]) drop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      for (int k = 0; k < N_CH; k++) time_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (accept[k]) begin
          pending_q[k] <= 1'b1;
          time_q[k]    <= match_time[ch_lsb(k, TW) +: TW];
        end else if (gnt_hot[k]) begin
          pending_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_dt    <= '0;
      ptr_q     <= '0;
    end else if (out_free) begin
      if (gnt_valid) begin
        out_valid <= 1'b1;
        out_ch    <= gnt_idx;
        // Modular difference; the top bit reads as sign (negative = early hit).
        out_dt    <= song_time - time_q[gnt_idx];
        ptr_q     <= (gnt_idx == IDW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_sc_match_serializer.sv
// Directed bench for sc_match_serializer at default parameters (37 channels,
// 16-bit time), with hand-computed expected records.
module tb_sc_match_serializer;
  localparam int N_CH = 37;
  localparam int TW   = 16;
  localparam int IDW  = 6;

  logic              clk;
  logic              rst_n;
  logic [TW-1:0]     song_time;
  logic [N_CH-1:0]   match_trigger;
  logic [N_CH*TW-1:0] match_time;
  logic              out_valid;
  logic              out_ready;
  logic [IDW-1:0]    out_ch;
  logic [TW-1:0]     out_dt;
  logic [N_CH-1:0]   pending;
  logic              overflow;
  logic              ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  sc_match_serializer #(.N_CH(N_CH), .TW(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .song_time     (song_time),
    .match_trigger (match_trigger),
    .match_time    (match_time),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ch        (out_ch),
    .out_dt        (out_dt),
    .pending       (pending),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k, input logic [TW-1:0] t);
    match_trigger[k] = 1'b1;
    match_time[k*TW +: TW] = t;
  endtask

  task automatic clear_trig();
    match_trigger = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_rec(input string tag, input logic [IDW-1:0] ch, input logic [TW-1:0] dt);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_ch"},    64'(out_ch),    64'(ch));
    check({tag, "_dt"},    64'(out_dt),    64'(dt));
  endtask

  logic [N_CH-1:0] exp_pend;

  initial begin
    rst_n = 1'b0;
    song_time = '0;
    match_trigger = '0;
    match_time = '0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    #3;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ch",    64'(out_ch),    64'd0);
    check("rst_dt",    64'(out_dt),    64'd0);
    check("rst_pend",  64'(pending),   64'd0);
    check("rst_ovf",   64'(overflow),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single event: 10 - 7 = 3, visible two edges after the pulse, for one cycle
    song_time = 16'd10;
    pulse(0, 16'd7);
    tick();
    clear_trig();
    check("single_pend", 64'(pending), 64'd1);
    check("single_early", 64'(out_valid), 64'd0);
    tick();
    check_rec("single", 6'd0, 16'd3);
    tick();
    check("single_once", 64'(out_valid), 64'd0);

    // simultaneous ch0/ch12/ch36 from pointer 0, song_time=100
    do_reset();
    song_time = 16'd100;
    pulse(0, 16'd90);
    pulse(12, 16'd95);
    pulse(36, 16'd110);
    tick();
    clear_trig();
    exp_pend = '0;
    exp_pend[0] = 1'b1; exp_pend[12] = 1'b1; exp_pend[36] = 1'b1;
    check("sim_pend", 64'(pending), 64'(exp_pend));
    tick();
    check_rec("sim0", 6'd0, 16'd10);
    tick();
    check_rec("sim12", 6'd12, 16'd5);
    tick();
    check_rec("sim36", 6'd36, 16'hFFF6);
    tick();
    check("sim_idle", 64'(out_valid), 64'd0);
    check("sim_pend_clr", 64'(pending), 64'd0);
    // pointer back at 0: ch0 must beat ch1
    pulse(1, 16'd99);
    pulse(0, 16'd98);
    tick();
    clear_trig();
    tick();
    check_rec("ptr0_a", 6'd0, 16'd2);
    tick();
    check_rec("ptr0_b", 6'd1, 16'd1);
    tick();

    // backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    song_time = 16'd50;
    pulse(5, 16'd20);
    tick();
    clear_trig();
    tick();
    check_rec("bp_load", 6'd5, 16'd30);
    for (int i = 0; i < 6; i++) begin
      song_time = 16'(50 + i * 7);
      clear_trig();
      ovf_clr = 1'b0;
      if (i == 1) pulse(5, 16'd40);
      if (i == 3) begin
        pulse(5, 16'd45);
        ovf_clr = 1'b1;
      end
      tick();
      check_rec($sformatf("bp_stall%0d", i), 6'd5, 16'd30);
      if (i == 1) check("bp_repend", 64'(pending[5]), 64'd1);
      if (i == 1) check("bp_no_ovf", 64'(overflow), 64'd0);
      if (i == 3) check("bp_ovf_set_wins", 64'(overflow), 64'd1);
    end
    clear_trig();
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    song_time = 16'd200;
    tick();
    check_rec("bp_second", 6'd5, 16'd160);
    tick();
    check("bp_one_only", 64'(out_valid), 64'd0);
    check("bp_pend_clr", 64'(pending), 64'd0);
    check("bp_ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("bp_ovf_clr", 64'(overflow), 64'd0);

    // same-cycle re-trigger on ch3
    do_reset();
    song_time = 16'd300;
    pulse(3, 16'd100);
    tick();
    pulse(3, 16'd250);
    tick();
    clear_trig();
    check_rec("rt_first", 6'd3, 16'd200);
    check("rt_pend", 64'(pending[3]), 64'd1);
    check("rt_no_ovf", 64'(overflow), 64'd0);
    tick();
    check_rec("rt_second", 6'd3, 16'd50);
    tick();
    check("rt_idle", 64'(out_valid), 64'd0);
    check("rt_ovf_end", 64'(overflow), 64'd0);

    // wrap and sign
    do_reset();
    song_time = 16'h0002;
    pulse(1, 16'hFFFE);
    tick();
    clear_trig();
    tick();
    check_rec("wrap_pos", 6'd1, 16'h0004);
    song_time = 16'h000C;
    pulse(2, 16'h0010);
    tick();
    clear_trig();
    tick();
    check_rec("wrap_neg", 6'd2, 16'hFFFC);
    tick();

    // asynchronous reset mid-operation
    do_reset();
    out_ready = 1'b0;
    song_time = 16'd77;
    pulse(7, 16'd70);
    tick();
    clear_trig();
    pulse(1, 16'd1); pulse(2, 16'd2); pulse(3, 16'd3); pulse(4, 16'd4);
    tick();
    clear_trig();
    check("ar_valid_pre", 64'(out_valid), 64'd1);
    check("ar_pend_pre", 64'(pending), 64'h1E);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_pend", 64'(pending), 64'd0);
    check("ar_dt", 64'(out_dt), 64'd0);
    check("ar_ch", 64'(out_ch), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ar_stale%0d", i), 64'(out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_match_serializer.md
Name: sc_match_serializer

Overview:
- Parametrised successor to the note-match buffer serializer.
- Captures per-string/per-note match triggers from N_CH parallel channels, each with its own note timestamp.
- Queues every trigger in a per-channel pending slot and drains them round-robin onto one valid/ready stream of (channel, signed timing error) records.
- Sits between the note-matching fabric and the scoring/feedback logic; no simultaneous match is lost, unlike the single-shot predecessor.

Parameters:
- N_CH, 37, number of match channels.
- TW, 16, width of song_time, match_time and dt.
- IDW, $clog2(N_CH) (6 at default), channel index width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- song_time  in  TW  current song time, free-running, wraps modulo 2^TW.
- match_trigger  in  N_CH  one-cycle match pulse per channel; a level held high counts as one event per cycle.
- match_time  in  N_CH*TW  note time of channel k at bits [k*TW +: TW]; sampled only when match_trigger[k]=1.
- out_valid  out  1  output record valid.
- out_ready  in  1  consumer accepts the record when out_valid & out_ready.
- out_ch  out  IDW  channel index of the record.
- out_dt  out  TW  signed two's complement song_time − match_time.
- pending  out  N_CH  per-channel pending flags (debug/status).
- overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release) clears:
  - out_valid=0, out_ch=0, out_dt=0.
  - pending=0, all stored times=0.
  - overflow=0.
  - round-robin pointer=0.
- Capture: at each edge with match_trigger[k]=1:
  - pending[k] is set and time_reg[k] is loaded from match_time slice k.
  - If pending[k] is already 1 and channel k is not granted in that same cycle, the new event is dropped, time_reg[k] is kept, and overflow is set.
  - If channel k is granted in the same cycle, the old entry is consumed and the new one is captured; no overflow.
- Arbitration (combinational):
  - Grant goes to the lowest pending index ≥ pointer, wrapping to 0..pointer−1.
  - Grant is only issued when the output register is free: out_valid=0, or out_valid & out_ready.
- Output load on grant:
  - out_valid=1, out_ch=g.
  - out_dt = song_time − time_reg[g], modulo 2^TW, where song_time is sampled in the grant cycle.
  - pending[g] is cleared.
  - pointer ← (g+1 == N_CH) ? 0 : g+1.
- No grant while the output register is free: out_valid ← 0.
- Stall: while out_valid & !out_ready, out_ch and out_dt are held bit-stable and no grant is issued.
- Latency: trigger high in cycle t → out_valid high in cycle t+2 when idle (capture edge, then grant edge).
- Throughput: one record per cycle when out_ready stays high.
- overflow: set takes priority over ovf_clr in the same cycle.
- Wrap-around: dt is purely modular. A negative out_dt means the hit was early.
- N_CH=1 must work with the pointer fixed at 0.

Decomposition:
- Shared header sc_defs: default N_CH, TW, and the channel-slice macro for match_time.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, en; outputs gnt_valid and gnt_idx.
- Pending/time registers, dt subtractor and output register stay in sc_match_serializer.

Test Plan:
- Single event: song_time=10, pulse ch0 with match_time=7, out_ready=1 → two cycles later out_valid=1, out_ch=0, out_dt=3 for exactly one cycle.
- Simultaneous events: pulse ch0, ch12 and ch36 in the same cycle, pointer=0, out_ready=1 → three back-to-back records in order ch0, ch12, ch36; pending returns to 0; pointer ends at 0.
- Backpressure and overflow: hold out_ready=0 for 6 cycles with ch5 pending.
  - Output record stays bit-stable throughout.
  - A second ch5 pulse during the stall sets overflow=1 and yields only one ch5 record.
  - ovf_clr then clears overflow.
- Same-cycle re-trigger: ch3 is being granted while a new ch3 pulse arrives → no overflow; two ch3 records total, the second using the new match_time.
- Wrap and sign:
  - song_time=0x0002, match_time=0xFFFE → out_dt=0x0004.
  - song_time=0x000C, match_time=0x0010 → out_dt=0xFFFC (−4).
- Reset mid-operation: assert rst_n=0 asynchronously while out_valid=1 and 4 channels pending → outputs and pending clear immediately without a clock edge; after release, no stale records appear.
